// File: rtl/pciei_sram_2port_pipe_if.sv
// Write/read port bundle for pciei_sram_2port_pipe. The parity signals exist only
// when PCIEI_SRAM_PARITY_EN is defined.
interface pciei_sram_2port_pipe_if #(
  parameter int DATA_WIDTH = 88,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  sram_wr_cen;
  logic [ADDR_WIDTH-1:0] sram_wr_a;
  logic [DATA_WIDTH-1:0] sram_wr_d;
  logic [NUM_BYTES-1:0]  sram_wr_be;
  logic                  sram_rd_cen;
  logic [ADDR_WIDTH-1:0] sram_rd_a;
  logic [DATA_WIDTH-1:0] sram_rd_q;
  logic                  sram_rd_vld;
  logic                  init_done;
`ifdef PCIEI_SRAM_PARITY_EN
  logic                  sram_wr_perr_inj;
  logic                  sram_rd_perr;

  modport master (
    output sram_wr_cen, sram_wr_a, sram_wr_d, sram_wr_be, sram_wr_perr_inj,
    output sram_rd_cen, sram_rd_a,
    input  sram_rd_q, sram_rd_vld, sram_rd_perr, init_done
  );
  modport slave (
    input  sram_wr_cen, sram_wr_a, sram_wr_d, sram_wr_be, sram_wr_perr_inj,
    input  sram_rd_cen, sram_rd_a,
    output sram_rd_q, sram_rd_vld, sram_rd_perr, init_done
  );
`else
  modport master (
    output sram_wr_cen, sram_wr_a, sram_wr_d, sram_wr_be,
    output sram_rd_cen, sram_rd_a,
    input  sram_rd_q, sram_rd_vld, init_done
  );
  modport slave (
    input  sram_wr_cen, sram_wr_a, sram_wr_d, sram_wr_be,
    input  sram_rd_cen, sram_rd_a,
    output sram_rd_q, sram_rd_vld, init_done
  );
`endif
endinterface

// File: rtl/pciei_sram_2port_pipe.sv
// Two-port SRAM model: byte-enabled write port, pipelined read port, self-clearing init.
// Optional per-byte even parity under macro PCIEI_SRAM_PARITY_EN.
module pciei_sram_2port_pipe #(
  parameter int DATA_WIDTH = 88,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_DEPTH  = 1024,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS_EN  = 1
) (
  input  logic clk,
  input  logic rst,
  pciei_sram_2port_pipe_if.slave bus
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int STAGES    = RD_LATENCY - 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || RD_LATENCY < 1 || RD_LATENCY > 4 ||
      RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("pciei_sram_2port_pipe: illegal parameter set");
  end

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];

  logic                  init_we, wr_ok, rd_ok, wr_act, rd_act, hit;
  logic [IDX_W-1:0]      init_idx, wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_old, rd_word;

  logic [STAGES:0]       vld_pipe;
  logic [DATA_WIDTH-1:0] q_pipe [STAGES+1];

  assign init_idx = init_addr[IDX_W-1:0];
  assign wr_idx   = bus.sram_wr_a[IDX_W-1:0];
  assign rd_idx   = bus.sram_rd_a[IDX_W-1:0];

  assign wr_ok   = {1'b0, bus.sram_wr_a} < DEPTH;
  assign rd_ok   = {1'b0, bus.sram_rd_a} < DEPTH;
  assign init_we = (state == S_INIT) && !rst;
  assign wr_act  = (state == S_READY) && !rst && !bus.sram_wr_cen && wr_ok;
  assign rd_act  = (state == S_READY) && !bus.sram_rd_cen;
  // Full-address compare; an out-of-range read is forced to zero, never merged.
  assign hit     = (BYPASS_EN != 0) && wr_act && rd_ok && (bus.sram_wr_a == bus.sram_rd_a);
  assign rd_old  = rd_ok ? ram[rd_idx] : '0;

`ifdef PCIEI_SRAM_PARITY_EN
  logic [NUM_BYTES-1:0] par [RAM_DEPTH];
  logic [NUM_BYTES-1:0] wr_par, rd_par_old, rd_par, perr_lane;
  logic [STAGES:0]      perr_pipe;

  assign rd_par_old = rd_ok ? par[rd_idx] : '0;
`endif

  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_lane
    localparam int LO = b * BYTE_WIDTH;
    logic take;
    assign take = hit && bus.sram_wr_be[b];
    assign rd_word[LO +: BYTE_WIDTH] = take ? bus.sram_wr_d[LO +: BYTE_WIDTH]
                                            : rd_old[LO +: BYTE_WIDTH];
`ifdef PCIEI_SRAM_PARITY_EN
    assign wr_par[b]    = (^bus.sram_wr_d[LO +: BYTE_WIDTH]) ^ bus.sram_wr_perr_inj;
    assign rd_par[b]    = take ? wr_par[b] : rd_par_old[b];
    assign perr_lane[b] = (^rd_word[LO +: BYTE_WIDTH]) ^ rd_par[b];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      init_addr <= '0;
    end else if (state == S_INIT) begin
      init_addr <= init_addr + ADDR_WIDTH'(1);
      if (init_addr == LAST_ADDR) state <= S_READY;
    end
  end

  // Array itself has no reset; the INIT sweep clears it after every rst.
  always_ff @(posedge clk) begin
    if (init_we) begin
      ram[init_idx] <= '0;
`ifdef PCIEI_SRAM_PARITY_EN
      par[init_idx] <= '0;
`endif
    end else if (wr_act) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (bus.sram_wr_be[b]) begin
          ram[wr_idx][b*BYTE_WIDTH +: BYTE_WIDTH] <= bus.sram_wr_d[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef PCIEI_SRAM_PARITY_EN
          par[wr_idx][b] <= wr_par[b];
`endif
        end
      end
    end
  end

  // Data stages only load behind a valid, so the output holds across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int s = 0; s <= STAGES; s++) q_pipe[s] <= '0;
    end else begin
      vld_pipe[0] <= rd_act;
      if (rd_act) q_pipe[0] <= rd_word;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) q_pipe[s] <= q_pipe[s-1];
      end
    end
  end

`ifdef PCIEI_SRAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_pipe <= '0;
    end else begin
      if (rd_act) perr_pipe[0] <= |perr_lane;
      for (int s = 1; s <= STAGES; s++)
        if (vld_pipe[s-1]) perr_pipe[s] <= perr_pipe[s-1];
    end
  end

  assign bus.sram_rd_perr = perr_pipe[STAGES] && vld_pipe[STAGES];
`endif

  assign bus.sram_rd_q   = q_pipe[STAGES];
  assign bus.sram_rd_vld = vld_pipe[STAGES];
  assign bus.init_done   = (state == S_READY);
endmodule

// File: tb/tb_pciei_sram_2port_pipe.sv
// Directed bench: dut_a (latency 3, bypass on) and dut_b (latency 2, bypass off), depth 16.
module tb_pciei_sram_2port_pipe;
  localparam int DW = 88, BW = 8, AW = 10, NB = 11, DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst    [2];
  logic          wr_cen [2];
  logic [AW-1:0] wr_a   [2];
  logic [DW-1:0] wr_d   [2];
  logic [NB-1:0] wr_be  [2];
  logic          rd_cen [2];
  logic [AW-1:0] rd_a   [2];
  wire  [DW-1:0] q      [2];
  wire           vld    [2];
  wire           done   [2];

  pciei_sram_2port_pipe_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus_a ();
  pciei_sram_2port_pipe_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus_b ();

  assign bus_a.sram_wr_cen = wr_cen[0];
  assign bus_a.sram_wr_a   = wr_a[0];
  assign bus_a.sram_wr_d   = wr_d[0];
  assign bus_a.sram_wr_be  = wr_be[0];
  assign bus_a.sram_rd_cen = rd_cen[0];
  assign bus_a.sram_rd_a   = rd_a[0];
  assign bus_b.sram_wr_cen = wr_cen[1];
  assign bus_b.sram_wr_a   = wr_a[1];
  assign bus_b.sram_wr_d   = wr_d[1];
  assign bus_b.sram_wr_be  = wr_be[1];
  assign bus_b.sram_rd_cen = rd_cen[1];
  assign bus_b.sram_rd_a   = rd_a[1];
  assign q[0]    = bus_a.sram_rd_q;
  assign q[1]    = bus_b.sram_rd_q;
  assign vld[0]  = bus_a.sram_rd_vld;
  assign vld[1]  = bus_b.sram_rd_vld;
  assign done[0] = bus_a.init_done;
  assign done[1] = bus_b.init_done;

`ifdef PCIEI_SRAM_PARITY_EN
  logic inj [2];
  wire  perr [2];
  assign bus_a.sram_wr_perr_inj = inj[0];
  assign bus_b.sram_wr_perr_inj = inj[1];
  assign perr[0] = bus_a.sram_rd_perr;
  assign perr[1] = bus_b.sram_rd_perr;
`endif

  pciei_sram_2port_pipe #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
    .RAM_DEPTH(DEPTH), .RD_LATENCY(3), .BYPASS_EN(1)) dut_a (.clk(clk), .rst(rst[0]), .bus(bus_a));
  pciei_sram_2port_pipe #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
    .RAM_DEPTH(DEPTH), .RD_LATENCY(2), .BYPASS_EN(0)) dut_b (.clk(clk), .rst(rst[1]), .bus(bus_b));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat(input bit s);
    return s ? 2 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit s, input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic [NB-1:0] be, input bit r, input logic [AW-1:0] ra);
    wr_cen[s] = !w; wr_a[s] = wa; wr_d[s] = wd; wr_be[s] = be;
    rd_cen[s] = !r; rd_a[s] = ra;
    tick();
    wr_cen[s] = 1'b1; rd_cen[s] = 1'b1;
  endtask

  task automatic wr(input bit s, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    op(s, 1'b1, a, d, be, 1'b0, '0);
  endtask

  // Optional same-cycle write; sample on the edge the read should land.
  task automatic rdw(input bit s, input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [NB-1:0] be, input logic [AW-1:0] ra,
                     output logic [DW-1:0] d, output logic v);
    op(s, w, wa, wd, be, 1'b1, ra);
    repeat (lat(s) - 1) tick();
    d = q[s]; v = vld[s];
  endtask

  task automatic rd(input bit s, input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    rdw(s, 1'b0, '0, '0, '0, a, d, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic          v, any;
    rst = '{1'b1, 1'b1};
    wr_cen = '{1'b1, 1'b1}; rd_cen = '{1'b1, 1'b1};
    wr_a = '{'0, '0}; rd_a = '{'0, '0}; wr_d = '{'0, '0}; wr_be = '{'0, '0};
`ifdef PCIEI_SRAM_PARITY_EN
    inj = '{1'b0, 1'b0};
`endif
    repeat (2) tick();
    chk("rst_vld", DW'(vld[0]), '0);
    chk("rst_q", q[0], '0);
    chk("rst_init_done", DW'(done[0]), '0);

    // Init sweep on both; dut_a has a read requested that must be ignored.
    rst = '{1'b0, 1'b0};
    rd_cen[0] = 1'b0; rd_a[0] = 10'd5;
    any = 1'b0;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      any = any | vld[0] | vld[1];
      if (e == 1)         chk("init_done_e1", DW'(done[0]), '0);
      if (e == DEPTH - 1) chk("init_done_e15", DW'(done[0]), '0);
      if (e == DEPTH - 2) rd_cen[0] = 1'b1;
    end
    chk("init_done_e16_a", DW'(done[0]), DW'(1));
    chk("init_done_e16_b", DW'(done[1]), DW'(1));
    chk("init_rd_vld", DW'(any), '0);
    rd(0, 10'd5, d, v);
    chk("post_init_q", d, '0);
    chk("post_init_vld", DW'(v), DW'(1));

    // Byte enables
    wr(0, 10'd3, {11{8'hAA}}, 11'h7FF);
    wr(0, 10'd3, {11{8'h55}}, 11'h001);
    wr(0, 10'd3, {11{8'hEE}}, 11'h000);
    rd(0, 10'd3, d, v);
    chk("be_merge", d, {{10{8'hAA}}, 8'h55});

    // Back-to-back reads through the 3-deep pipe
    wr(0, 10'd1, {11{8'h01}}, 11'h7FF);
    wr(0, 10'd2, {11{8'h02}}, 11'h7FF);
    wr(0, 10'd3, {11{8'h03}}, 11'h7FF);
    rd_cen[0] = 1'b0; rd_a[0] = 10'd1;
    tick(); chk("lat_e0_vld", DW'(vld[0]), '0);
    rd_a[0] = 10'd2;
    tick(); chk("lat_e1_vld", DW'(vld[0]), '0);
    rd_a[0] = 10'd3;
    tick(); chk("lat_e2_vld", DW'(vld[0]), DW'(1)); chk("lat_e2_q", q[0], {11{8'h01}});
    rd_cen[0] = 1'b1;
    tick(); chk("lat_e3_vld", DW'(vld[0]), DW'(1)); chk("lat_e3_q", q[0], {11{8'h02}});
    tick(); chk("lat_e4_vld", DW'(vld[0]), DW'(1)); chk("lat_e4_q", q[0], {11{8'h03}});
    tick(); chk("idle_vld", DW'(vld[0]), '0);     chk("idle_q_hold", q[0], {11{8'h03}});

    // Collisions, bypass on
    wr(0, 10'd7, {11{8'h11}}, 11'h7FF);
    rdw(0, 1'b1, 10'd7, {11{8'h22}}, 11'h7FF, 10'd7, d, v);
    chk("byp_full", d, {11{8'h22}});
    rdw(0, 1'b1, 10'd7, {11{8'h33}}, 11'h002, 10'd7, d, v);
    chk("byp_partial", d, {{9{8'h22}}, 8'h33, 8'h22});
    rdw(0, 1'b1, 10'd6, {11{8'h44}}, 11'h7FF, 10'd7, d, v);
    chk("diff_addr", d, {{9{8'h22}}, 8'h33, 8'h22});

    // Out of range: write dropped (no alias into addr 4), read gives 0 with valid
    rdw(0, 1'b1, 10'd20, {11{8'h77}}, 11'h7FF, 10'd20, d, v);
    chk("oob_q", d, '0);
    chk("oob_vld", DW'(v), DW'(1));
    rd(0, 10'd4, d, v);
    chk("oob_no_alias", d, '0);

    // Collision, bypass off
    wr(1, 10'd7, {11{8'h11}}, 11'h7FF);
    rdw(1, 1'b1, 10'd7, {11{8'h22}}, 11'h7FF, 10'd7, d, v);
    chk("nobyp_old", d, {11{8'h11}});
    rd(1, 10'd7, d, v);
    chk("nobyp_after", d, {11{8'h22}});

    // Reset with a read in flight
    wr(1, 10'd4, {11{8'h33}}, 11'h7FF);
    rd_cen[1] = 1'b0; rd_a[1] = 10'd4;
    tick();
    rd_cen[1] = 1'b1; rst[1] = 1'b1;
    tick();
    chk("rst_mid_vld", DW'(vld[1]), '0);
    chk("rst_mid_q", q[1], '0);
    rst[1] = 1'b0;
    any = 1'b0;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      any = any | vld[1];
      if (e == DEPTH - 1) chk("reinit_e15", DW'(done[1]), '0);
    end
    chk("reinit_e16", DW'(done[1]), DW'(1));
    chk("reinit_no_vld", DW'(any), '0);
    rd(1, 10'd4, d, v);
    chk("reinit_cleared", d, '0);
    chk("reinit_vld", DW'(v), DW'(1));

`ifdef PCIEI_SRAM_PARITY_EN
    inj[0] = 1'b1;
    wr(0, 10'd9, {11{8'h5A}}, 11'h7FF);
    inj[0] = 1'b0;
    rd(0, 10'd9, d, v);
    chk("perr_inj", DW'(perr[0]), DW'(1));
    chk("perr_inj_vld", DW'(v), DW'(1));
    wr(0, 10'd9, {11{8'h5A}}, 11'h7FF);
    rd(0, 10'd9, d, v);
    chk("perr_clean", DW'(perr[0]), '0);
    inj[0] = 1'b1;
    rdw(0, 1'b1, 10'd9, {11{8'h01}}, 11'h001, 10'd9, d, v);
    inj[0] = 1'b0;
    chk("perr_bypass", DW'(perr[0]), DW'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
